// File: rtl/one_to_two_eight_demux_buf_if.sv
// Stream and status bundle for the buffered 1-to-2 byte demultiplexer.
// The design sits on the slave modport; its driver sits on the master modport.
interface one_to_two_eight_demux_buf_if #(
  parameter int CNT_W = 8
);
  logic             mode;
  logic [7:0]       in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [7:0]       out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  modport slave (
    input  mode, in_data, in_sel, in_valid, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
  );

  modport master (
    output mode, in_data, in_sel, in_valid, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
  );
endinterface

// File: rtl/one_to_two_eight_demux_buf.sv
// Buffered 1-to-2 byte demultiplexer: one valid/ready input stream steered by select
// or round-robin into two independent first-word-fall-through FIFOs.
module one_to_two_eight_demux_buf #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  one_to_two_eight_demux_buf_if.slave bus
);
  localparam int               AW       = $clog2(DEPTH);
  localparam int               PTR_W    = AW + 1;
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] FULL_OCC = PTR_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [7:0]       mem_r  [2][DEPTH];
  logic [PTR_W-1:0] wptr_r [2];
  logic [PTR_W-1:0] rptr_r [2];
  logic [CNT_W-1:0] cnt_r  [2];
  logic             rr_r;

  logic [PTR_W-1:0] occ_s      [2];
  logic             full_s     [2];
  logic             valid_s    [2];
  logic             rd_ready_s [2];
  logic             push_s     [2];
  logic             pop_s      [2];
  logic             eff_sel_s;
  logic             in_ready_s;
  logic             accept_s;

  // Per-channel occupancy and status, derived only from registered pointers.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      occ_s[c]   = wptr_r[c] - rptr_r[c];
      full_s[c]  = (occ_s[c] == FULL_OCC);
      valid_s[c] = (occ_s[c] != PTR_ZERO);
    end
  end

  // Channel selection, input handshake and push/pop strobes.
  always_comb begin
    rd_ready_s[0] = bus.out0_ready;
    rd_ready_s[1] = bus.out1_ready;
    if (bus.mode) begin
      eff_sel_s = rr_r;
    end else begin
      eff_sel_s = bus.in_sel;
    end
    // No bypass: a full channel refuses a beat even when it pops this cycle.
    in_ready_s = ~full_s[eff_sel_s];
    accept_s   = bus.in_valid & in_ready_s;
    for (int c = 0; c < 2; c++) begin
      push_s[c] = accept_s & (eff_sel_s == 1'(c));
      pop_s[c]  = valid_s[c] & rd_ready_s[c];
    end
  end

  // FIFO pointers and accepted-beat counters; reset discards all buffered data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < 2; c++) begin
        wptr_r[c] <= PTR_ZERO;
        rptr_r[c] <= PTR_ZERO;
        cnt_r[c]  <= CNT_ZERO;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push_s[c]) begin
          wptr_r[c] <= wptr_r[c] + PTR_ONE;
          cnt_r[c]  <= cnt_r[c] + CNT_ONE;
        end
        if (pop_s[c]) begin
          rptr_r[c] <= rptr_r[c] + PTR_ONE;
        end
      end
    end
  end

  // Round-robin toggle; holds across mode=0 periods so alternation resumes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_r <= 1'b0;
    end else if (accept_s && bus.mode) begin
      rr_r <= ~rr_r;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (push_s[c]) begin
        mem_r[c][wptr_r[c][AW-1:0]] <= bus.in_data;
      end
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out0_valid = valid_s[0];
  assign bus.out1_valid = valid_s[1];
  assign bus.out0_data  = mem_r[0][rptr_r[0][AW-1:0]];
  assign bus.out1_data  = mem_r[1][rptr_r[1][AW-1:0]];
  assign bus.cnt0       = cnt_r[0];
  assign bus.cnt1       = cnt_r[1];
endmodule

// File: tb/tb_one_to_two_eight_demux_buf.sv
// Directed bench for the buffered 1-to-2 byte demultiplexer; every expected value
// below is hand-derived from the intended behaviour.
module tb_one_to_two_eight_demux_buf;
  logic clk;
  logic reset_n;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  one_to_two_eight_demux_buf_if #(.CNT_W(8)) bus ();

  one_to_two_eight_demux_buf #(.DEPTH(4), .CNT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    bus.mode = 1'b0; bus.in_sel = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'hEE;
    bus.out0_ready = 1'b0; bus.out1_ready = 1'b0;
    #2 reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vec_cnt++; if (bus.out0_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_out0_valid: got %b want 0", bus.out0_valid); end
      vec_cnt++; if (bus.out1_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_out1_valid: got %b want 0", bus.out1_valid); end
      vec_cnt++; if (bus.cnt0 !== 8'd0) begin err_cnt++; $display("FAIL rst_cnt0: got %0d want 0", bus.cnt0); end
      vec_cnt++; if (bus.cnt1 !== 8'd0) begin err_cnt++; $display("FAIL rst_cnt1: got %0d want 0", bus.cnt1); end
    end
    bus.in_valid = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_stream0();
    logic [7:0] v;
    bus.mode = 1'b0; bus.in_sel = 1'b0; bus.out0_ready = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      v = 8'(8'h11 * (i + 1));
      bus.in_data = v;
      #1;
      vec_cnt++; if (bus.in_ready !== 1'b1) begin err_cnt++; $display("FAIL s0_in_ready: got %b want 1", bus.in_ready); end
      step();
      vec_cnt++; if (bus.out0_valid !== 1'b1 || bus.out0_data !== v) begin err_cnt++; $display("FAIL s0_out0: got v=%b d=%h want v=1 d=%h", bus.out0_valid, bus.out0_data, v); end
      vec_cnt++; if (bus.out1_valid !== 1'b0) begin err_cnt++; $display("FAIL s0_out1_valid: got %b want 0", bus.out1_valid); end
    end
    bus.in_valid = 1'b0;
    step();
    vec_cnt++; if (bus.out0_valid !== 1'b0) begin err_cnt++; $display("FAIL s0_drain: got %b want 0", bus.out0_valid); end
    vec_cnt++; if (bus.cnt0 !== 8'd3 || bus.cnt1 !== 8'd0) begin err_cnt++; $display("FAIL s0_cnt: got %0d/%0d want 3/0", bus.cnt0, bus.cnt1); end
    bus.out0_ready = 1'b0;
  endtask

  task automatic test_full_backpressure();
    int         exp_idx;
    int         sent;
    logic       pop_now;
    logic       acc_now;
    logic [7:0] want;
    bus.mode = 1'b0; bus.in_sel = 1'b1; bus.out1_ready = 1'b0; bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = 8'(8'hA0 + i);
      #1;
      vec_cnt++; if (bus.in_ready !== 1'b1) begin err_cnt++; $display("FAIL fb_fill_ready%0d: got %b want 1", i, bus.in_ready); end
      step();
    end
    bus.in_data = 8'hA4;
    #1;
    vec_cnt++; if (bus.in_ready !== 1'b0) begin err_cnt++; $display("FAIL fb_full_ready: got %b want 0", bus.in_ready); end
    step();
    vec_cnt++; if (bus.cnt1 !== 8'd4 || bus.out1_data !== 8'hA0) begin err_cnt++; $display("FAIL fb_held: got cnt1=%0d d=%h want 4/a0", bus.cnt1, bus.out1_data); end
    bus.out1_ready = 1'b1;
    #1;
    vec_cnt++; if (bus.in_ready !== 1'b0) begin err_cnt++; $display("FAIL fb_no_bypass: got %b want 0", bus.in_ready); end
    step();
    bus.out1_ready = 1'b0;
    #1;
    vec_cnt++; if (bus.cnt1 !== 8'd4 || bus.out1_data !== 8'hA1 || bus.in_ready !== 1'b1) begin err_cnt++; $display("FAIL fb_after_pop: got cnt1=%0d d=%h rdy=%b want 4/a1/1", bus.cnt1, bus.out1_data, bus.in_ready); end
    step();
    vec_cnt++; if (bus.cnt1 !== 8'd5) begin err_cnt++; $display("FAIL fb_a4_accept: got %0d want 5", bus.cnt1); end
    exp_idx = 1; sent = 5; bus.out1_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && exp_idx < 6; cyc++) begin
      bus.in_valid = (sent < 6);
      bus.in_data  = 8'(8'hA0 + sent);
      #1;
      pop_now = bus.out1_valid;
      acc_now = bus.in_valid & bus.in_ready;
      if (pop_now) begin
        want = 8'(8'hA0 + exp_idx);
        vec_cnt++; if (bus.out1_data !== want) begin err_cnt++; $display("FAIL fb_order: got %h want %h", bus.out1_data, want); end
      end
      step();
      if (pop_now) exp_idx++;
      if (acc_now) sent++;
    end
    bus.in_valid = 1'b0;
    vec_cnt++; if (exp_idx != 6) begin err_cnt++; $display("FAIL fb_drain_timeout: got %0d beats want 6", exp_idx); end
    vec_cnt++; if (bus.cnt1 !== 8'd6 || bus.out1_valid !== 1'b0) begin err_cnt++; $display("FAIL fb_final: got cnt1=%0d v=%b want 6/0", bus.cnt1, bus.out1_valid); end
    bus.out1_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [7:0] want;
    logic       ch;
    bus.mode = 1'b1; bus.out0_ready = 1'b1; bus.out1_ready = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      want = 8'(i + 1);
      if (i == 7) bus.mode = 1'b0;
      else        bus.mode = 1'b1;
      bus.in_sel  = (i == 7) ? 1'b0 : 1'($urandom_range(0, 1));
      bus.in_data = want;
      // Beats 1..7 alternate from rr=0; beat 8 is explicit to ch0, beat 9 resumes with rr=1.
      ch = (i == 8) ? 1'b1 : ((i == 7) ? 1'b0 : 1'(i % 2));
      #1;
      vec_cnt++; if (bus.in_ready !== 1'b1) begin err_cnt++; $display("FAIL rr_ready%0d: got %b want 1", i, bus.in_ready); end
      step();
      if (ch) begin
        vec_cnt++; if (bus.out1_valid !== 1'b1 || bus.out1_data !== want) begin err_cnt++; $display("FAIL rr_out1_%0d: got v=%b d=%h want 1/%h", i, bus.out1_valid, bus.out1_data, want); end
      end else begin
        vec_cnt++; if (bus.out0_valid !== 1'b1 || bus.out0_data !== want) begin err_cnt++; $display("FAIL rr_out0_%0d: got v=%b d=%h want 1/%h", i, bus.out0_valid, bus.out0_data, want); end
      end
    end
    bus.in_valid = 1'b0; bus.mode = 1'b0;
    step();
    vec_cnt++; if (bus.cnt0 !== 8'd8 || bus.cnt1 !== 8'd10) begin err_cnt++; $display("FAIL rr_cnt: got %0d/%0d want 8/10", bus.cnt0, bus.cnt1); end
    bus.out0_ready = 1'b0; bus.out1_ready = 1'b0;
  endtask

  task automatic test_channel_independence();
    bus.mode = 1'b0; bus.in_sel = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = 8'(8'hB0 + i);
      step();
    end
    #1;
    vec_cnt++; if (bus.in_ready !== 1'b0) begin err_cnt++; $display("FAIL ci_ch1_full: got %b want 0", bus.in_ready); end
    bus.in_sel = 1'b0; bus.in_data = 8'h55;
    #1;
    vec_cnt++; if (bus.in_ready !== 1'b1) begin err_cnt++; $display("FAIL ci_ready55: got %b want 1", bus.in_ready); end
    step();
    bus.in_data = 8'h66;
    #1;
    vec_cnt++; if (bus.in_ready !== 1'b1) begin err_cnt++; $display("FAIL ci_ready66: got %b want 1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    vec_cnt++; if (bus.out0_valid !== 1'b1 || bus.out0_data !== 8'h55) begin err_cnt++; $display("FAIL ci_out55: got v=%b d=%h want 1/55", bus.out0_valid, bus.out0_data); end
    bus.out0_ready = 1'b1;
    step();
    vec_cnt++; if (bus.out0_data !== 8'h66) begin err_cnt++; $display("FAIL ci_out66: got %h want 66", bus.out0_data); end
    step();
    vec_cnt++; if (bus.out0_valid !== 1'b0 || bus.out1_data !== 8'hB0) begin err_cnt++; $display("FAIL ci_end: got v0=%b d1=%h want 0/b0", bus.out0_valid, bus.out1_data); end
    bus.out0_ready = 1'b0;
  endtask

  task automatic test_simul_push_pop();
    logic [7:0] seq [5];
    seq[0] = 8'h60; seq[1] = 8'h61; seq[2] = 8'h70; seq[3] = 8'h71; seq[4] = 8'h72;
    bus.mode = 1'b0; bus.in_sel = 1'b0; bus.in_valid = 1'b1;
    bus.in_data = 8'h60; step();
    bus.in_data = 8'h61; step();
    bus.out0_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = 8'(8'h70 + i);
      #1;
      vec_cnt++; if (bus.in_ready !== 1'b1 || bus.out0_data !== seq[i]) begin err_cnt++; $display("FAIL sp_%0d: got rdy=%b d=%h want 1/%h", i, bus.in_ready, bus.out0_data, seq[i]); end
      step();
    end
    bus.out0_ready = 1'b0;
    bus.in_data = 8'h75; step();
    bus.in_data = 8'h76; step();
    bus.in_data = 8'h77;
    #1;
    // Two extra beats fill the FIFO only if occupancy stayed at two during the overlap.
    vec_cnt++; if (bus.in_ready !== 1'b0 || bus.out0_data !== 8'h73) begin err_cnt++; $display("FAIL sp_occ: got rdy=%b d=%h want 0/73", bus.in_ready, bus.out0_data); end
    bus.in_valid = 1'b0;
    vec_cnt++; if (bus.cnt0 !== 8'd19 || bus.cnt1 !== 8'd14) begin err_cnt++; $display("FAIL sp_cnt: got %0d/%0d want 19/14", bus.cnt0, bus.cnt1); end
  endtask

  task automatic test_async_reset_wrap();
    #2 reset_n = 1'b0;
    #1;
    vec_cnt++; if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0) begin err_cnt++; $display("FAIL ar_valid: got %b/%b want 0/0", bus.out0_valid, bus.out1_valid); end
    vec_cnt++; if (bus.cnt0 !== 8'd0 || bus.cnt1 !== 8'd0) begin err_cnt++; $display("FAIL ar_cnt: got %0d/%0d want 0/0", bus.cnt0, bus.cnt1); end
    step();
    reset_n = 1'b1;
    step();
    vec_cnt++; if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0) begin err_cnt++; $display("FAIL ar_stale: got %b/%b want 0/0", bus.out0_valid, bus.out1_valid); end
    bus.mode = 1'b0; bus.in_sel = 1'b1; bus.in_data = 8'hC3; bus.in_valid = 1'b1;
    #1;
    vec_cnt++; if (bus.in_ready !== 1'b1) begin err_cnt++; $display("FAIL ar_ready: got %b want 1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    vec_cnt++; if (bus.out1_valid !== 1'b1 || bus.out1_data !== 8'hC3) begin err_cnt++; $display("FAIL ar_first: got v=%b d=%h want 1/c3", bus.out1_valid, bus.out1_data); end
    bus.out1_ready = 1'b1;
    step();
    bus.out1_ready = 1'b0;
    bus.in_sel = 1'b0; bus.out0_ready = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 257; i++) begin
      bus.in_data = 8'(i);
      step();
    end
    bus.in_valid = 1'b0;
    step();
    vec_cnt++; if (bus.cnt0 !== 8'd1 || bus.cnt1 !== 8'd1 || bus.out0_valid !== 1'b0) begin err_cnt++; $display("FAIL wrap: got cnt0=%0d cnt1=%0d v0=%b want 1/1/0", bus.cnt0, bus.cnt1, bus.out0_valid); end
    bus.out0_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream0();
    test_full_backpressure();
    test_round_robin();
    test_channel_independence();
    test_simul_push_pop();
    test_async_reset_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/one_to_two_eight_demux_buf.md
Name: one_to_two_eight_demux_buf

Overview:
- Buffered 1-to-2 byte demultiplexer for the PE datapath.
- Steers a single 8-bit valid/ready input stream into one of two 8-bit output channels.
- Each output channel has its own FIFO, so one stalled consumer does not drop data.
- It is the distribution counterpart of the PE's 8-bit 2-to-1 selection path: one source fans out to two operand lanes, either under explicit select or in round-robin.

Parameters:
- DEPTH, 4, entries per output FIFO; power of two, at least 2.
- CNT_W, 8, width of the per-channel accepted-beat counters.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = route by in_sel; 1 = alternate channel 0/1 per accepted beat.
- in_data  input  8  input byte.
- in_sel  input  1  target channel when mode=0; ignored when mode=1.
- in_valid  input  1  input beat present.
- in_ready  output  1  input beat can be accepted this cycle.
- out0_data  output  8  channel 0 head byte.
- out0_valid  output  1  channel 0 FIFO not empty.
- out0_ready  input  1  channel 0 consumer accepts.
- out1_data  output  8  channel 1 head byte.
- out1_valid  output  1  channel 1 FIFO not empty.
- out1_ready  input  1  channel 1 consumer accepts.
- cnt0  output  CNT_W  beats pushed into channel 0 since reset.
- cnt1  output  CNT_W  beats pushed into channel 1 since reset.

Behaviour:
- Reset: asynchronous, active-low, on reset_n only; no other reset input exists.
  - Asserting reset_n low immediately clears both FIFO read/write pointers and occupancies, the rr toggle (to 0), cnt0 and cnt1.
  - out0_valid, out1_valid, cnt0 and cnt1 go to 0 without waiting for a clock edge.
  - out*_data is don't-care while its valid is 0.
  - This holds mid-operation: all buffered data is discarded.
- Effective select: eff_sel = in_sel when mode=0, rr when mode=1.
- Input handshake:
  - in_ready = NOT full(eff_sel), combinational from registered occupancy, mode, in_sel and rr.
  - A beat is accepted on a rising edge where in_valid && in_ready.
  - in_ready does not depend on in_valid.
  - A beat on a full channel stalls; it is never redirected to the other channel and never dropped.
- Push: an accepted beat writes in_data into FIFO[eff_sel], advances that write pointer, and increments cnt[eff_sel], wrapping modulo 2^CNT_W.
- Round-robin: rr toggles only on an accepted beat while mode=1.
  - rr holds its value while mode=0.
  - A mode change takes effect for the next beat; rr is not cleared by the mode change.
- Output, first-word-fall-through:
  - outN_valid = occupancyN != 0.
  - outN_data = entry at the read pointer.
  - A pop happens on a rising edge where outN_valid && outN_ready and advances the read pointer.
  - outN_ready while outN_valid=0 has no effect.
- Latency:
  - A beat accepted at edge k appears on outN_valid/outN_data after edge k when the FIFO was empty: one-cycle latency.
  - Order is preserved per channel.
- Simultaneous push and pop on the same FIFO: occupancy is unchanged, both pointers advance, and the data remains correct.
  - When full, push is blocked even if a pop occurs the same cycle; in_ready reflects full only, with no bypass.
- Pointer width is log2(DEPTH)+1 (extra wrap bit), or an occupancy counter of the same width; pointers wrap at DEPTH.
- Channels are independent: a full or stalled channel 1 never blocks beats steered to channel 0.

Test Plan:
- Reset and stream to channel 0:
  - Stimulus: hold reset_n=0 for 3 cycles with in_valid=1; release; mode=0, in_sel=0; send 0x11,0x22,0x33 with out0_ready=1.
  - Required: all valid and cnt outputs are 0 during reset; out0 sees 0x11,0x22,0x33 each one cycle after acceptance; out1_valid stays 0; cnt0=3, cnt1=0.
- Full and back-pressure:
  - Stimulus: mode=0, in_sel=1, out1_ready=0; drive 0xA0..0xA5 back-to-back.
  - Required: the first 4 beats are accepted, then in_ready=0 with 0xA4 held.
  - Stimulus: raise out1_ready for 1 cycle.
  - Required: 0xA0 pops; 0xA4 is accepted the next edge, not the same edge as the pop.
  - Final order on out1 is 0xA0..0xA5; cnt1=6.
- Round-robin with select ignored:
  - Stimulus: mode=1, in_sel toggled randomly; send 0x01..0x06 with both readies high.
  - Required: out0 gets 0x01,0x03,0x05 and out1 gets 0x02,0x04,0x06.
  - Stimulus: switch to mode=0 and back.
  - Required: alternation resumes from the saved rr.
- Channel independence:
  - Stimulus: fill channel 1 (out1_ready=0); then route 0x55,0x66 to channel 0.
  - Required: both are accepted with in_ready=1 and are delivered on out0.
- Simultaneous push and pop:
  - Stimulus: occupancy0=2; in_valid and out0_ready both high for 5 cycles with data 0x70..0x74.
  - Required: occupancy0 stays at 2 throughout; FIFO order is preserved.
- Async reset mid-traffic and counter wrap:
  - Stimulus: with both FIFOs partially full, pulse reset_n low between clock edges.
  - Required: valids drop immediately; cnt outputs are 0; no stale data appears after release.
  - Stimulus: push 257 beats to channel 0.
  - Required: cnt0=1.
